// File: rtl/f100l_mem_pkg.sv
// Shared types and constants for the memory_bus arbiter/sequencer.
// Covers FSM encoding, owner ids, bank ids and the latched request payload.
package f100l_mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam logic [1:0] BANK_RAM    = 2'b00;
    localparam logic [1:0] BANK_ROM    = 2'b01;
    localparam logic [1:0] BANK_PERIPH = 2'b10;
    localparam logic [1:0] BANK_BRAM   = 2'b11;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    function automatic logic [1:0] bank_of(input logic [ADDR_W-1:0] address);
        return address[14:13];
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Requester ports plus the memory_bus side of the arbiter, bundled as one interface.
// slave = arbiter view, master = requester/memory environment view.
interface memory_bus_arbiter_if;
    import f100l_mem_pkg::*;

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data_in;
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_ready;

    logic              dma_req;
    logic              dma_write;
    logic [ADDR_W-1:0] dma_address;
    logic [DATA_W-1:0] dma_data_in;
    logic [DATA_W-1:0] dma_data_out;
    logic              dma_ready;

    logic              owner;
    logic              busy;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_bus_enable;
    logic              mem_write_enable;

    modport slave (
        input  cpu_req, cpu_write, cpu_address, cpu_data_in,
        input  dma_req, dma_write, dma_address, dma_data_in,
        input  mem_data_in,
        output cpu_data_out, cpu_ready, dma_data_out, dma_ready,
        output owner, busy,
        output mem_address, mem_data_out, mem_bus_enable, mem_write_enable
    );

    modport master (
        output cpu_req, cpu_write, cpu_address, cpu_data_in,
        output dma_req, dma_write, dma_address, dma_data_in,
        output mem_data_in,
        input  cpu_data_out, cpu_ready, dma_data_out, dma_ready,
        input  owner, busy,
        input  mem_address, mem_data_out, mem_bus_enable, mem_write_enable
    );

endinterface

// File: rtl/memory_bus_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not own last.
module rr_arbiter2
    import f100l_mem_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWNER_CPU;
        if (cpu_req && dma_req) begin
            grant_owner = (last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
        end else if (dma_req) begin
            grant_owner = OWNER_DMA;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// CPU/DMA arbiter and fixed-handshake access sequencer for memory_bus.
// Every output is a register; the round-robin pick only feeds next-state logic.
module memory_bus_arbiter
    import f100l_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic                 clk,
    input logic                 reset,
    memory_bus_arbiter_if.slave bus
);

    if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("memory_bus_arbiter: WAIT_CYCLES must be within 1..15");
    end

    arb_state_t        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bus_en_q, bus_en_d;
    logic              we_q, we_d;
    logic              cpu_rdy_q, cpu_rdy_d;
    logic              dma_rdy_q, dma_rdy_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              grant_valid;
    logic              grant_owner;
    mem_req_t          win_req;

    rr_arbiter2 u_rr_arbiter2 (
        .cpu_req     (bus.cpu_req),
        .dma_req     (bus.dma_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next-state and next-output values; registers hold unless a state says otherwise.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bus_en_d     = bus_en_q;
        we_d         = 1'b0;
        cpu_rdy_d    = 1'b0;
        dma_rdy_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        win_req.write   = bus.cpu_write;
        win_req.address = bus.cpu_address;
        win_req.data    = bus.cpu_data_in;
        if (grant_owner == OWNER_DMA) begin
            win_req.write   = bus.dma_write;
            win_req.address = bus.dma_address;
            win_req.data    = bus.dma_data_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d  = ST_ISSUE;
                    owner_d  = grant_owner;
                    busy_d   = 1'b1;
                    wr_d     = win_req.write;
                    addr_d   = win_req.address;
                    wdata_d  = win_req.data;
                    bus_en_d = 1'b1;
                    we_d     = win_req.write;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    cpu_rdy_d = (owner_q == OWNER_CPU);
                    dma_rdy_d = (owner_q == OWNER_DMA);
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                bus_en_d     = 1'b0;
                last_owner_d = owner_q;
                if (!wr_q) begin
                    if (owner_q == OWNER_DMA) dma_rdata_d = bus.mem_data_in;
                    else                      cpu_rdata_d = bus.mem_data_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_DMA;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            owner_q      <= OWNER_CPU;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus_en_q     <= 1'b0;
            we_q         <= 1'b0;
            cpu_rdy_q    <= 1'b0;
            dma_rdy_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bus_en_q     <= bus_en_d;
            we_q         <= we_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dma_rdy_q    <= dma_rdy_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.owner            = owner_q;
    assign bus.busy             = busy_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_data_out     = wdata_q;
    assign bus.mem_bus_enable   = bus_en_q;
    assign bus.mem_write_enable = we_q;
    assign bus.cpu_ready        = cpu_rdy_q;
    assign bus.dma_ready        = dma_rdy_q;
    assign bus.cpu_data_out     = cpu_rdata_q;
    assign bus.dma_data_out     = dma_rdata_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized CPU/DMA traffic against a cycle-count reference model with a ready-driven scoreboard,
// plus a directed long-wait peripheral read on a second instance.
module tb_memory_bus_arbiter;
    import f100l_mem_pkg::*;

    localparam int unsigned W  = 1;
    localparam int unsigned WB = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memory_bus_arbiter_if bus ();
    memory_bus_arbiter_if bus_b ();

    memory_bus_arbiter #(.WAIT_CYCLES(W))  dut   (.clk(clk), .reset(reset), .bus(bus));
    memory_bus_arbiter #(.WAIT_CYCLES(WB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Environment memory behind memory_bus: write lands on the ISSUE edge, read data is registered.
    logic [15:0] phys    [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] addr_tab [8] = '{16'h0010, 16'h0020, 16'h0030, 16'h2010,
                                  16'h4000, 16'h6020, 16'h8010, 16'hE000};

    always @(posedge clk) begin
        if (bus.mem_bus_enable && bus.mem_write_enable) phys[bus.mem_address] = bus.mem_data_out;
        bus.mem_data_in   <= phys.exists(bus.mem_address) ? phys[bus.mem_address] : init_val(bus.mem_address);
        bus_b.mem_data_in <= init_val(bus_b.mem_address);
    end

    // Reference model: bus free/busy by cycle arithmetic, round-robin by last winner.
    typedef struct {
        bit          port;
        bit          write;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        int          ready_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    exp_t        mdl_e;
    bit          cur_valid  = 1'b0;
    int          cur_t      = 0;
    int          free_at    = 0;
    bit          last_owner = 1'b1;
    logic [15:0] last_addr  = 16'h0;
    logic [15:0] last_mdo   = 16'h0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            cur_valid  = 1'b0;
            last_owner = 1'b1;
            free_at    = cyc + 1;
            last_addr  = 16'h0;
            last_mdo   = 16'h0;
            exp_q.delete();
        end else if (cyc >= free_at && (bus.cpu_req || bus.dma_req)) begin
            mdl_e.port  = (bus.cpu_req && bus.dma_req) ? ~last_owner : bit'(bus.dma_req);
            mdl_e.write = mdl_e.port ? bus.dma_write   : bus.cpu_write;
            mdl_e.addr  = mdl_e.port ? bus.dma_address : bus.cpu_address;
            mdl_e.data  = mdl_e.port ? bus.dma_data_in : bus.cpu_data_in;
            mdl_e.rdata = ref_mem.exists(mdl_e.addr) ? ref_mem[mdl_e.addr] : init_val(mdl_e.addr);
            if (mdl_e.write) ref_mem[mdl_e.addr] = mdl_e.data;
            mdl_e.ready_cyc = cyc + int'(W) + 1;
            exp_q.push_back(mdl_e);
            cur        = mdl_e;
            cur_t      = cyc;
            cur_valid  = 1'b1;
            last_owner = mdl_e.port;
            free_at    = cyc + int'(W) + 3;
            last_addr  = mdl_e.addr;
            last_mdo   = mdl_e.data;
        end
    end

    // Monitor: per-cycle control checks plus scoreboard pop on every ready pulse.
    logic [15:0] exp_do [2];
    bit          pend_valid  = 1'b0;
    exp_t        pend;
    exp_t        mon_e;
    int          completions = 0;

    initial begin
        exp_do[0] = 16'h0;
        exp_do[1] = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                exp_do[0]  = 16'h0;
                exp_do[1]  = 16'h0;
                pend_valid = 1'b0;
            end else begin
                bit in_acc;
                int c;
                if (pend_valid) begin
                    if (!pend.write) exp_do[pend.port] = pend.rdata;
                    pend_valid = 1'b0;
                end
                c      = cyc - cur_t;
                in_acc = cur_valid && (c <= int'(W) + 1);
                check("cpu_data_out", 32'(bus.cpu_data_out), 32'(exp_do[0]));
                check("dma_data_out", 32'(bus.dma_data_out), 32'(exp_do[1]));
                check("busy", 32'(bus.busy), 32'(in_acc));
                check("mem_bus_enable", 32'(bus.mem_bus_enable), 32'(in_acc));
                check("mem_write_enable", 32'(bus.mem_write_enable), 32'(in_acc && c == 0 && cur.write));
                check("cpu_ready", 32'(bus.cpu_ready), 32'(in_acc && c == int'(W) + 1 && !cur.port));
                check("dma_ready", 32'(bus.dma_ready), 32'(in_acc && c == int'(W) + 1 && cur.port));
                check("mem_address", 32'(bus.mem_address), 32'(last_addr));
                check("mem_data_out", 32'(bus.mem_data_out), 32'(last_mdo));
                if (in_acc) check("owner", 32'(bus.owner), 32'(cur.port));
                if (bus.cpu_ready || bus.dma_ready) begin
                    check("single_ready", 32'(bus.cpu_ready && bus.dma_ready), 32'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got ready with empty scoreboard (cycle %0d)", cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("ready_port", 32'(bus.dma_ready), 32'(mon_e.port));
                        check("ready_cycle", 32'(cyc), 32'(mon_e.ready_cyc));
                        check("done_address", 32'(bus.mem_address), 32'(mon_e.addr));
                        completions++;
                        pend       = mon_e;
                        pend_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Requester behaviour: hold req until ready, drop it, optionally idle, then re-request.
    bit stop = 1'b0;

    task automatic drive_port(input bit port, input bit r, input bit w,
                              input logic [15:0] a, input logic [15:0] d);
        if (port) begin
            bus.dma_req = r; bus.dma_write = w; bus.dma_address = a; bus.dma_data_in = d;
        end else begin
            bus.cpu_req = r; bus.cpu_write = w; bus.cpu_address = a; bus.cpu_data_in = d;
        end
    endtask

    task automatic run_driver(input bit port);
        bit          active = 1'b0;
        int          gap    = 0;
        int          waited = 0;
        int          n      = 0;
        bit          w      = 1'b0;
        logic [15:0] a      = 16'h0;
        logic [15:0] d      = 16'h0;
        drive_port(port, 1'b0, 1'b0, 16'h0, 16'h0);
        forever begin
            @(negedge clk);
            if (!reset) begin
                drive_port(port, 1'b0, w, a, d);
                active = 1'b0;
                gap    = 0;
            end else if (active) begin
                if (port ? bus.dma_ready : bus.cpu_ready) begin
                    drive_port(port, 1'b0, w, a, d);
                    active = 1'b0;
                    gap    = (n < 6) ? 0 : int'($urandom_range(0, 5));
                end else begin
                    waited++;
                    if (waited > 60) begin
                        checks++;
                        errors++;
                        $display("FAIL ready_timeout: port %0d got no ready within 60 cycles (cycle %0d)", port, cyc);
                        drive_port(port, 1'b0, w, a, d);
                        active = 1'b0;
                    end
                end
            end else if (gap > 0) begin
                gap--;
            end else if (!stop) begin
                w = 1'($urandom_range(0, 1));
                a = addr_tab[int'($urandom_range(0, 7))];
                d = 16'($urandom);
                if (!port && n == 0)      begin w = 1'b0; a = 16'h0010; end
                else if (!port && n == 1) begin w = 1'b0; a = 16'h0020; end
                else if (port && n == 0)  begin w = 1'b1; a = 16'h0020; d = 16'hBEEF; end
                drive_port(port, 1'b1, w, a, d);
                active = 1'b1;
                waited = 0;
                n++;
            end
        end
    endtask

    // Long-wait read on the second instance: ready in cycle 17, address held throughout.
    task automatic run_periph_test();
        int ready_at = -1;
        bit we_seen  = 1'b0;
        @(negedge clk);
        bus_b.cpu_write   = 1'b0;
        bus_b.cpu_address = 16'h4000;
        bus_b.cpu_req     = 1'b1;
        for (int k = 1; k <= 40 && ready_at < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus_b.mem_write_enable) we_seen = 1'b1;
            if (bus_b.cpu_ready) begin
                ready_at      = k;
                bus_b.cpu_req = 1'b0;
            end
            if (k <= 17) begin
                check("periph_mem_address", 32'(bus_b.mem_address), 32'h4000);
                check("periph_bus_enable", 32'(bus_b.mem_bus_enable), 32'(1));
            end
        end
        bus_b.cpu_req = 1'b0;
        check("periph_ready_cycle", 32'(ready_at), 32'(17));
        check("periph_write_enable", 32'(we_seen), 32'(0));
        @(posedge clk);
        #1;
        check("periph_data_out", 32'(bus_b.cpu_data_out), 32'(init_val(16'h4000)));
    endtask

    task automatic wait_completions(input int target, input string name);
        int g = 0;
        while (completions < target && g < 4000) begin
            @(posedge clk);
            g++;
        end
        if (completions < target) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d completions required %0d", name, completions, target);
        end
    endtask

    initial begin
        int g;
        phys[16'h0010]    = 16'h1234;
        ref_mem[16'h0010] = 16'h1234;
        bus_b.cpu_req = 1'b0; bus_b.cpu_write = 1'b0; bus_b.cpu_address = 16'h0; bus_b.cpu_data_in = 16'h0;
        bus_b.dma_req = 1'b0; bus_b.dma_write = 1'b0; bus_b.dma_address = 16'h0; bus_b.dma_data_in = 16'h0;
        fork
            run_driver(1'b0);
            run_driver(1'b1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_cpu_data_out", 32'(bus.cpu_data_out), 32'(0));
        #1 reset = 1'b1;

        run_periph_test();
        wait_completions(150, "random_phase");

        // Abort an access during WAIT.
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(cur_valid && (cyc - cur_t) >= 1 && (cyc - cur_t) <= int'(W)) && g < 200);
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL find_wait_state: got no WAIT cycle in 200 cycles required one");
        end
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_owner", 32'(bus.owner), 32'(0));
        check("midrst_cpu_ready", 32'(bus.cpu_ready), 32'(0));
        check("midrst_dma_ready", 32'(bus.dma_ready), 32'(0));
        check("midrst_mem_address", 32'(bus.mem_address), 32'(0));
        check("midrst_mem_data_out", 32'(bus.mem_data_out), 32'(0));
        check("midrst_bus_enable", 32'(bus.mem_bus_enable), 32'(0));
        check("midrst_write_enable", 32'(bus.mem_write_enable), 32'(0));
        check("midrst_cpu_data_out", 32'(bus.cpu_data_out), 32'(0));
        check("midrst_dma_data_out", 32'(bus.dma_data_out), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_tie_busy", 32'(bus.busy), 32'(1));
        check("post_reset_tie_owner", 32'(bus.owner), 32'(OWNER_CPU));

        wait_completions(completions + 20, "post_reset_phase");
        stop = 1'b1;
        repeat (20) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
